inverse_cdf_sign_restore: RTL and testbench

INVERSE_CDF_SIGN_RESTORE -- requirements
Module: inverse_cdf_sign_restore

---
 rtl/inverse_cdf_sign_restore.sv | 97 +++++++++
 tb/tb_inverse_cdf_sign_restore.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_cdf_sign_restore.sv
// Sign-restore stage for the inverse-CDF datapath: pairs each unsigned |z| magnitude with the
// negate flag queued by the fold stage, clamps it to the signed range and applies the sign.
module inverse_cdf_sign_restore #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned QINT  = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flag_valid,
  input  logic                     negate,
  output logic                     flag_ready,
  input  logic                     mag_valid,
  input  logic [WIDTH-1:0]         mag,
  output logic                     mag_ready,
  output logic                     z_valid,
  output logic [WIDTH-1:0]         z,
  input  logic                     z_ready,
  output logic                     sat,
  output logic [$clog2(DEPTH):0]   flag_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};

  if (QINT > WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $error("inverse_cdf_sign_restore: bad QINT/DEPTH parameters");
  end

  logic [DEPTH-1:0] flag_mem_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             z_valid_q, z_valid_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             sat_q, sat_d;
  logic             push, pop;
  logic [WIDTH-1:0] mag_clamp;

  always_comb begin
    // count never exceeds DEPTH, so its MSB alone marks a full queue
    flag_ready = !count_q[CntW-1];
    mag_ready  = (count_q != '0) && (!z_valid_q || z_ready);
    push       = flag_valid && flag_ready;
    pop        = mag_valid && mag_ready;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    mag_clamp = mag[WIDTH-1] ? MaxPos : mag;

    z_valid_d = z_valid_q;
    z_d       = z_q;
    sat_d     = sat_q;
    if (pop) begin
      z_valid_d = 1'b1;
      sat_d     = mag[WIDTH-1];
      z_d       = flag_mem_q[rd_ptr_q] ? (~mag_clamp + WIDTH'(1)) : mag_clamp;
    end else if (z_ready) begin
      z_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      z_valid_q  <= 1'b0;
      z_q        <= '0;
      sat_q      <= 1'b0;
    end else begin
      if (push) begin
        flag_mem_q[wr_ptr_q] <= negate;
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q   <= count_d;
      z_valid_q <= z_valid_d;
      z_q       <= z_d;
      sat_q     <= sat_d;
    end
  end

  assign z_valid    = z_valid_q;
  assign z          = z_q;
  assign sat        = sat_q;
  assign flag_count = count_q;

endmodule

// File: tb/tb_inverse_cdf_sign_restore.sv
// Bench for inverse_cdf_sign_restore: directed literal cases plus randomized traffic checked
// every cycle against a queue-based model of the flag FIFO and result register.
module tb_inverse_cdf_sign_restore;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flag_valid = 1'b0, negate = 1'b0, flag_ready;
  logic          mag_valid = 1'b0, mag_ready;
  logic [W-1:0]  mag = '0;
  logic          z_valid, z_ready = 1'b1, sat;
  logic [W-1:0]  z;
  logic [4:0]    flag_count;

  int vectors = 0;
  int errors = 0;

  // model state
  bit            fq[$];
  bit            m_zv;
  logic [W-1:0]  m_z;
  bit            m_sat;
  bit            hold_mag;

  inverse_cdf_sign_restore #(.WIDTH(W), .QINT(16), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_valid (flag_valid),
    .negate     (negate),
    .flag_ready (flag_ready),
    .mag_valid  (mag_valid),
    .mag        (mag),
    .mag_ready  (mag_ready),
    .z_valid    (z_valid),
    .z          (z),
    .z_ready    (z_ready),
    .sat        (sat),
    .flag_count (flag_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed result from plain integer arithmetic: clamp to +max, then optionally negate.
  function automatic logic [W-1:0] ref_z(input logic [W-1:0] m, input bit neg, output bit s);
    longint v;
    longint maxp;
    logic [63:0] r;
    maxp = (longint'(1) <<< (W - 1)) - 1;
    v = longint'({32'd0, m});
    s = 1'b0;
    if (v > maxp) begin
      v = maxp;
      s = 1'b1;
    end
    r = neg ? -v : v;
    return r[W-1:0];
  endfunction

  function automatic bit m_flag_ready();
    return fq.size() < D;
  endfunction

  function automatic bit m_mag_ready();
    return (fq.size() > 0) && (!m_zv || z_ready);
  endfunction

  task automatic model_reset();
    fq.delete();
    m_zv = 1'b0;
    m_z = '0;
    m_sat = 1'b0;
    hold_mag = 1'b0;
  endtask

  task automatic check_outputs();
    chk("flag_ready", flag_ready, m_flag_ready());
    chk("mag_ready", mag_ready, m_mag_ready());
    chk("flag_count", flag_count, fq.size());
    chk("z_valid", z_valid, m_zv);
    if (m_zv) begin
      chk("z", z, m_z);
      chk("sat", sat, m_sat);
    end
  endtask

  task automatic model_step();
    bit push, pop, f, s;
    push = flag_valid && m_flag_ready();
    pop  = mag_valid && m_mag_ready();
    hold_mag = mag_valid && !pop;
    if (pop) begin
      f = fq.pop_front();
      m_z = ref_z(mag, f, s);
      m_sat = s;
      m_zv = 1'b1;
    end else if (z_ready) begin
      m_zv = 1'b0;
    end
    if (push) fq.push_back(negate);
  endtask

  // Inputs are set at the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    flag_valid = 1'b0;
    mag_valid = 1'b0;
    z_ready = 1'b1;
  endtask

  task automatic drain();
    idle();
    mag_valid = 1'b1;
    mag = 32'h0000_4000;
    repeat (D + 2) cycle();
    idle();
    cycle();
  endtask

  logic [W-1:0] held_z;
  logic [4:0]   held_cnt;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst flag_count", flag_count, 0);
    chk("rst flag_ready", flag_ready, 1);
    chk("rst mag_ready", mag_ready, 0);
    chk("rst z_valid", z_valid, 0);
    chk("rst z", z, 0);
    chk("rst sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // -1.5
    flag_valid = 1'b1; negate = 1'b1;
    cycle();
    flag_valid = 1'b0; mag_valid = 1'b1; mag = 32'h0001_8000;
    cycle();
    idle();
    #1;
    chk("neg1p5 z_valid", z_valid, 1);
    chk("neg1p5 z", z, 32'hFFFE_8000);
    chk("neg1p5 sat", sat, 0);
    cycle();

    // FIFO pairing, back-to-back
    flag_valid = 1'b1;
    negate = 1'b0; cycle();
    negate = 1'b1; cycle();
    negate = 1'b0; cycle();
    flag_valid = 1'b0;
    mag_valid = 1'b1; mag = 32'h0001_0000; cycle();
    mag = 32'h0002_0000; #1 chk("b2b z0", z, 32'h0001_0000); cycle();
    mag = 32'h0003_0000; #1 chk("b2b z1", z, 32'hFFFE_0000); cycle();
    mag_valid = 1'b0;    #1 chk("b2b z2", z, 32'h0003_0000);
    chk("b2b v2", z_valid, 1);
    cycle();

    // saturation both signs
    flag_valid = 1'b1;
    negate = 1'b0; cycle();
    negate = 1'b1; cycle();
    flag_valid = 1'b0;
    mag_valid = 1'b1; mag = 32'h9000_0000; cycle();
    #1 chk("sat pos z", z, 32'h7FFF_FFFF); chk("sat pos s", sat, 1);
    cycle();
    mag_valid = 1'b0;
    #1 chk("sat neg z", z, 32'h8000_0001); chk("sat neg s", sat, 1);
    cycle();

    // zero magnitude with negate
    flag_valid = 1'b1; negate = 1'b1; cycle();
    flag_valid = 1'b0; mag_valid = 1'b1; mag = '0; cycle();
    mag_valid = 1'b0;
    #1 chk("zero z", z, 0); chk("zero sat", sat, 0);
    cycle();

    // fill to full
    flag_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      negate = i[0];
      cycle();
    end
    #1 chk("full count", flag_count, 16); chk("full ready", flag_ready, 0);
    cycle();
    #1 chk("17th count", flag_count, 16);
    flag_valid = 1'b0; mag_valid = 1'b1; mag = 32'h0000_1000;
    cycle();
    mag_valid = 1'b0;
    #1 chk("pop count", flag_count, 15); chk("pop ready", flag_ready, 1);
    cycle();
    drain();

    // backpressure
    flag_valid = 1'b1; negate = 1'b1; cycle(); cycle(); cycle();
    flag_valid = 1'b0; mag_valid = 1'b1; mag = 32'h0005_0000; cycle();
    z_ready = 1'b0; mag = 32'h0006_0000;
    #1 held_z = z; held_cnt = flag_count;
    chk("bp first z", held_z, 32'hFFFB_0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      #1 chk("bp z held", z, held_z); chk("bp mag_ready", mag_ready, 0);
      chk("bp count held", flag_count, held_cnt);
    end
    z_ready = 1'b1;
    #1 chk("bp release mag_ready", mag_ready, 1);
    cycle();
    mag_valid = 1'b0;
    #1 chk("bp next z", z, 32'hFFFA_0000); chk("bp next count", flag_count, held_cnt - 5'd1);
    cycle();
    drain();

    // reset mid-operation
    flag_valid = 1'b1; negate = 1'b0;
    repeat (6) cycle();
    flag_valid = 1'b0; mag_valid = 1'b1; mag = 32'h0007_0000; cycle();
    mag_valid = 1'b0;
    #1 chk("pre-rst count", flag_count, 5); chk("pre-rst zv", z_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async count", flag_count, 0); chk("async zv", z_valid, 0); chk("async z", z, 0);
    chk("async flag_ready", flag_ready, 1); chk("async mag_ready", mag_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mag_valid = 1'b1; mag = 32'h0001_0000;
    cycle();
    cycle();
    flag_valid = 1'b1; negate = 1'b1;
    #1 chk("post-rst mag_ready", mag_ready, 0);
    cycle();
    flag_valid = 1'b0;
    #1 chk("post-push mag_ready", mag_ready, 1);
    cycle();
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      flag_valid = ($urandom_range(0, 3) != 0);
      negate = $urandom_range(0, 1);
      z_ready = ($urandom_range(0, 3) != 0);
      if (!hold_mag) begin
        mag_valid = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 5))
          0: mag = '0;
          1: mag = 32'h7FFF_FFFF;
          2: mag = 32'h8000_0000;
          3: mag = $urandom;
          default: mag = $urandom_range(0, 32'h000F_FFFF);
        endcase
      end
      if (n % 97 == 50) flag_valid = 1'b0;
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
